// File: rtl/cpu_fetch.sv
// ---------------------------------------------------------------------------
// cpu_fetch -- instruction fetch unit for the MiniSoC CPU.
//
// Fetches three consecutive words (opcode, opa, opb) starting at pc_o over a
// req/ack memory bus. It then pulses fetch_done_o for one cycle and waits for
// the executor's exec_done_i. On completion the PC advances either by STEP or
// to the jump target, and retired_o counts the completed instruction.
//
// Ports
//   clk_i         clock, rising edge
//   rst_n_i       asynchronous active-low reset
//   enable_i      run enable; a started instruction always completes
//   mem_req_o     memory read request (held until acked)
//   mem_addr_o    byte address of the requested word
//   mem_ack_i     read complete, mem_rdata_i valid this cycle
//   mem_rdata_i   read data
//   opcode_o/opa_o/opb_o  fetched instruction words
//   fetch_done_o  one-cycle instruction valid strobe
//   exec_done_i   executor finished the issued instruction
//   newpc_i       jump target, used when isjcc_i is set
//   isjcc_i       issued instruction was a taken jump
//   pc_o          address of the current/next instruction
//   retired_o     number of completed instructions (wraps)
// ---------------------------------------------------------------------------
module cpu_fetch #(
  parameter int                 WIDTH    = 32,
  parameter logic [WIDTH-1:0]   RESET_PC = '0,
  parameter logic [WIDTH-1:0]   STEP     = WIDTH'(12)
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             enable_i,
  output logic             mem_req_o,
  output logic [WIDTH-1:0] mem_addr_o,
  input  logic             mem_ack_i,
  input  logic [WIDTH-1:0] mem_rdata_i,
  output logic [WIDTH-1:0] opcode_o,
  output logic [WIDTH-1:0] opa_o,
  output logic [WIDTH-1:0] opb_o,
  output logic             fetch_done_o,
  input  logic             exec_done_i,
  input  logic [WIDTH-1:0] newpc_i,
  input  logic             isjcc_i,
  output logic [WIDTH-1:0] pc_o,
  output logic [WIDTH-1:0] retired_o
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    FETCH     = 2'd1,
    ISSUE     = 2'd2,
    WAIT_EXEC = 2'd3
  } state_t;

  state_t           state;
  logic [1:0]       widx;
  logic [WIDTH-1:0] pc_next;

  // Address of the instruction after the one in flight; only meaningful at
  // the WAIT_EXEC completion edge, which is the only place it is used.
  always_comb begin
    pc_next = isjcc_i ? newpc_i : pc_o + STEP;
  end

  // NOTE: every register here uses non-blocking assignments so all state
  // updates see the values from before the edge, independent of order.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state        <= IDLE;
      widx         <= 2'd0;
      mem_req_o    <= 1'b0;
      mem_addr_o   <= RESET_PC;
      pc_o         <= RESET_PC;
      opcode_o     <= '0;
      opa_o        <= '0;
      opb_o        <= '0;
      fetch_done_o <= 1'b0;
      retired_o    <= '0;
    end else begin
      fetch_done_o <= 1'b0;
      case (state)
        IDLE: begin
          if (enable_i) begin
            state      <= FETCH;
            widx       <= 2'd0;
            mem_req_o  <= 1'b1;
            mem_addr_o <= pc_o;
          end
        end

        FETCH: begin
          // Request and address stay put until the word is acknowledged.
          if (mem_ack_i) begin
            case (widx)
              2'd0:    opcode_o <= mem_rdata_i;
              2'd1:    opa_o    <= mem_rdata_i;
              default: opb_o    <= mem_rdata_i;
            endcase
            if (widx == 2'd2) begin
              state        <= ISSUE;
              widx         <= 2'd0;
              mem_req_o    <= 1'b0;
              fetch_done_o <= 1'b1;
            end else begin
              widx       <= widx + 2'd1;
              // Tracks pc_o + 4*widx; the request stays high for the next word.
              mem_addr_o <= mem_addr_o + WIDTH'(4);
            end
          end
        end

        ISSUE: begin
          // exec_done_i is deliberately not looked at in this cycle.
          state <= WAIT_EXEC;
        end

        WAIT_EXEC: begin
          if (exec_done_i) begin
            pc_o       <= pc_next;
            mem_addr_o <= pc_next;
            retired_o  <= retired_o + WIDTH'(1);
            widx       <= 2'd0;
            if (enable_i) begin
              state     <= FETCH;
              mem_req_o <= 1'b1;
            end else begin
              state <= IDLE;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
